// File: rtl/tdc_meas_seq.sv
// tdc_meas_seq: burst measurement sequencer for the tdc_delay TDC.
// Runs N start/stop measurements with a programmable start-to-stop interval.
// Each sample is accumulated into sum/min/max, and the burst result is
// offered on a valid/ready interface.
module tdc_meas_seq #(
  parameter int CNT_W  = 32,
  parameter int SETTLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  input  logic [7:0]         cfg_delay,
  input  logic [3:0]         cfg_samples,
  output logic               tdc_start,
  output logic               tdc_stop,
  input  logic [CNT_W-1:0]   tdc_count,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W+3:0]   res_sum,
  output logic [CNT_W-1:0]   res_min,
  output logic [CNT_W-1:0]   res_max,
  output logic [4:0]         res_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SETTLE,
    S_CAPTURE,
    S_GAP,
    S_DONE
  } state_t;

  // Last value of the in-state cycle counter for the settle window.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;       // cycles spent in the current state
  logic [7:0]         dly_q, dly_d;       // effective start-to-stop interval D
  logic [4:0]         nsmp_q, nsmp_d;     // burst length N
  logic [CNT_W+3:0]   acc_sum_q, acc_sum_d;
  logic [CNT_W-1:0]   acc_min_q, acc_min_d;
  logic [CNT_W-1:0]   acc_max_q, acc_max_d;
  logic [4:0]         acc_n_q, acc_n_d;
  logic [CNT_W+3:0]   res_sum_q, res_sum_d;
  logic [CNT_W-1:0]   res_min_q, res_min_d;
  logic [CNT_W-1:0]   res_max_q, res_max_d;
  logic [4:0]         res_n_q, res_n_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

  // Next-state, accumulator and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 8'd1;
    dly_d     = dly_q;
    nsmp_d    = nsmp_q;
    acc_sum_d = acc_sum_q;
    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    acc_n_d   = acc_n_q;
    res_sum_d = res_sum_q;
    res_min_d = res_min_q;
    res_max_d = res_max_q;
    res_n_d   = res_n_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (go) begin
          dly_d     = (cfg_delay == 8'd0) ? 8'd1 : cfg_delay;
          nsmp_d    = {1'b0, cfg_samples} + 5'd1;
          acc_sum_d = '0;
          acc_min_d = '1;
          acc_max_d = '0;
          acc_n_d   = 5'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (cnt_q == dly_q - 8'd1) begin
          cnt_d   = 8'd0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // The sample is the count present during this single cycle.
        acc_sum_d = acc_sum_q + {4'b0000, tdc_count};
        if (tdc_count < acc_min_q) acc_min_d = tdc_count;
        if (tdc_count > acc_max_q) acc_max_d = tdc_count;
        acc_n_d   = acc_n_q + 5'd1;
        cnt_d     = 8'd0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == 8'd1) begin
          cnt_d   = 8'd0;
          state_d = (acc_n_q < nsmp_q) ? S_START : S_DONE;
        end
      end
      S_DONE: begin
        cnt_d = 8'd0;
        if (valid_q && res_ready) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over every other transition outside IDLE.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end

    // Result registers are only loaded when a burst completes, so they hold
    // the last completed burst through IDLE and aborted bursts.
    if ((state_q == S_GAP) && (state_d == S_DONE)) begin
      res_sum_d = acc_sum_q;
      res_min_d = acc_min_q;
      res_max_d = acc_max_q;
      res_n_d   = acc_n_q;
    end

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state they describe.
    start_d = (state_d == S_START) || (state_d == S_SETTLE) || (state_d == S_CAPTURE);
    stop_d  = (state_d == S_SETTLE) || (state_d == S_CAPTURE);
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      dly_q     <= 8'd1;
      nsmp_q    <= 5'd1;
      acc_sum_q <= '0;
      acc_min_q <= '0;
      acc_max_q <= '0;
      acc_n_q   <= 5'd0;
      res_sum_q <= '0;
      res_min_q <= '0;
      res_max_q <= '0;
      res_n_q   <= 5'd0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      nsmp_q    <= nsmp_d;
      acc_sum_q <= acc_sum_d;
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      acc_n_q   <= acc_n_d;
      res_sum_q <= res_sum_d;
      res_min_q <= res_min_d;
      res_max_q <= res_max_d;
      res_n_q   <= res_n_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign tdc_start = start_q;
  assign tdc_stop  = stop_q;
  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign res_sum   = res_sum_q;
  assign res_min   = res_min_q;
  assign res_max   = res_max_q;
  assign res_n     = res_n_q;

endmodule

// File: tb/tb_tdc_meas_seq.sv
// Directed testbench for tdc_meas_seq with hand-computed expectations.
module tb_tdc_meas_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        abort;
  logic [7:0]  cfg_delay;
  logic [3:0]  cfg_samples;
  logic        tdc_start;
  logic        tdc_stop;
  logic [31:0] tdc_count;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [35:0] res_sum;
  logic [31:0] res_min;
  logic [31:0] res_max;
  logic [4:0]  res_n;

  int errors = 0;
  int checks = 0;

  logic [31:0] vals [16];
  int r_valid_cyc, r_pulses, r_first_start, r_last_start;
  int r_first_stop, r_last_stop, r_start_hi, r_stop_hi, r_gap_bad;

  tdc_meas_seq #(.CNT_W(32), .SETTLE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .abort       (abort),
    .cfg_delay   (cfg_delay),
    .cfg_samples (cfg_samples),
    .tdc_start   (tdc_start),
    .tdc_stop    (tdc_stop),
    .tdc_count   (tdc_count),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_min     (res_min),
    .res_max     (res_max),
    .res_n       (res_n)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accept a burst at the next edge (edge 0); returns in cycle 1.
  // Config inputs are scrambled afterwards to show they are not sampled again.
  task automatic issue_go(input logic [7:0] dly, input logic [3:0] smp);
    cfg_delay   = dly;
    cfg_samples = smp;
    go          = 1'b1;
    step(1);
    go          = 1'b0;
    cfg_delay   = 8'hAA;
    cfg_samples = 4'h0;
  endtask

  // Observe one burst from cycle 1 until res_valid, feeding vals[k] to the
  // TDC count from the cycle start k rises.
  task automatic run_burst(input int limit);
    int  c;
    int  last_start_c;
    logic prev_start;
    r_valid_cyc = 0; r_pulses = 0; r_first_start = 0; r_last_start = 0;
    r_first_stop = 0; r_last_stop = 0; r_start_hi = 0; r_stop_hi = 0; r_gap_bad = 0;
    prev_start = 1'b0;
    last_start_c = 0;
    c = 1;
    while (c <= limit) begin
      if (tdc_start) begin
        r_start_hi++;
        if (r_first_start == 0) r_first_start = c;
        r_last_start = c;
      end
      if (tdc_stop) begin
        r_stop_hi++;
        if (r_first_stop == 0) r_first_stop = c;
        r_last_stop = c;
      end
      if (tdc_start && !prev_start) begin
        if (r_pulses > 0 && (c - last_start_c - 1) != 2) r_gap_bad++;
        if (r_pulses < 16) tdc_count = vals[r_pulses];
        r_pulses++;
      end
      if (tdc_start) last_start_c = c;
      prev_start = tdc_start;
      if (res_valid) begin
        r_valid_cyc = c;
        break;
      end
      step(1);
      c++;
    end
    if (r_valid_cyc == 0) check_val("burst_timeout", 64'd0, 64'd1);
    $display("burst: valid@%0d pulses=%0d sum=0x%0h min=0x%0h max=0x%0h n=%0d",
             r_valid_cyc, r_pulses, res_sum, res_min, res_max, res_n);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
  endtask

  initial begin
    int vcount;
    rst = 1'b1; go = 1'b0; abort = 1'b0; cfg_delay = 8'd0; cfg_samples = 4'd0;
    tdc_count = 32'd0; res_ready = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);

    // Reset state
    check_val("rst_start", tdc_start, 0);
    check_val("rst_stop",  tdc_stop, 0);
    check_val("rst_busy",  busy, 0);
    check_val("rst_valid", res_valid, 0);
    check_val("rst_sum",   res_sum, 0);
    check_val("rst_min",   res_min, 0);
    check_val("rst_max",   res_max, 0);
    check_val("rst_n",     res_n, 0);

    // Single sample, D=3
    vals[0] = 32'h0000_00FF;
    issue_go(8'd3, 4'd0);
    run_burst(200);
    check_val("s1_first_start", r_first_start, 1);
    check_val("s1_last_start",  r_last_start, 8);
    check_val("s1_start_hi",    r_start_hi, 8);
    check_val("s1_first_stop",  r_first_stop, 4);
    check_val("s1_last_stop",   r_last_stop, 8);
    check_val("s1_valid_cyc",   r_valid_cyc, 11);
    check_val("s1_sum", res_sum, 36'hFF);
    check_val("s1_min", res_min, 32'hFF);
    check_val("s1_max", res_max, 32'hFF);
    check_val("s1_n",   res_n, 1);
    handshake();
    check_val("s1_valid_drop", res_valid, 0);
    check_val("s1_busy_drop",  busy, 0);

    // Burst of 4, D=2: period 9, valid at 37
    vals[0] = 32'd10; vals[1] = 32'd40; vals[2] = 32'd20; vals[3] = 32'd30;
    issue_go(8'd2, 4'd3);
    run_burst(400);
    check_val("b4_pulses",    r_pulses, 4);
    check_val("b4_gap",       r_gap_bad, 0);
    check_val("b4_valid_cyc", r_valid_cyc, 37);
    check_val("b4_sum", res_sum, 100);
    check_val("b4_min", res_min, 10);
    check_val("b4_max", res_max, 40);
    check_val("b4_n",   res_n, 4);
    handshake();

    // cfg_delay=0 behaves as 1
    vals[0] = 32'h1234;
    issue_go(8'd0, 4'd0);
    run_burst(200);
    check_val("d0_first_start", r_first_start, 1);
    check_val("d0_first_stop",  r_first_stop, 2);
    check_val("d0_start_hi",    r_start_hi, 6);
    check_val("d0_valid_cyc",   r_valid_cyc, 9);
    check_val("d0_sum", res_sum, 32'h1234);
    handshake();

    // Backpressure: result held, go in DONE ignored
    vals[0] = 32'd5; vals[1] = 32'd7;
    issue_go(8'd1, 4'd1);
    run_burst(200);
    check_val("bp_valid_cyc", r_valid_cyc, 17);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        go = 1'b1; cfg_delay = 8'd9; cfg_samples = 4'd9;
      end
      step(1);
      go = 1'b0;
      check_val("bp_valid", res_valid, 1);
      check_val("bp_busy",  busy, 1);
      check_val("bp_sum",   res_sum, 12);
      check_val("bp_min",   res_min, 5);
      check_val("bp_max",   res_max, 7);
      check_val("bp_n",     res_n, 2);
    end
    handshake();
    check_val("bp_valid_drop", res_valid, 0);
    check_val("bp_busy_drop",  busy, 0);
    step(2);
    check_val("bp_go_not_queued", busy, 0);
    $display("backpressure: released, busy=%0d", busy);

    // Abort in SETTLE of sample 2 (D=3: sample 2 SETTLE is cycles 14-17)
    tdc_count = 32'd3;
    issue_go(8'd3, 4'd3);
    step(14);
    check_val("ab_in_settle", tdc_stop, 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check_val("ab_start", tdc_start, 0);
    check_val("ab_stop",  tdc_stop, 0);
    check_val("ab_busy",  busy, 0);
    check_val("ab_valid", res_valid, 0);
    vcount = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (res_valid) vcount++;
    end
    check_val("ab_no_result", vcount, 0);
    check_val("ab_res_kept",  res_n, 2);
    $display("abort: done, res_n=%0d", res_n);

    // Reset in SETTLE of sample 2
    issue_go(8'd3, 4'd3);
    step(14);
    check_val("rs_in_settle", tdc_stop, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_val("rs_start", tdc_start, 0);
    check_val("rs_stop",  tdc_stop, 0);
    check_val("rs_busy",  busy, 0);
    check_val("rs_valid", res_valid, 0);
    check_val("rs_sum",   res_sum, 0);
    check_val("rs_min",   res_min, 0);
    check_val("rs_max",   res_max, 0);
    check_val("rs_n",     res_n, 0);
    $display("reset: done");

    // Max range: 16 samples of all-ones, D=1: valid at 16*8+1
    for (int i = 0; i < 16; i++) vals[i] = 32'hFFFF_FFFF;
    issue_go(8'd1, 4'd15);
    run_burst(1000);
    check_val("mx_pulses",    r_pulses, 16);
    check_val("mx_valid_cyc", r_valid_cyc, 129);
    check_val("mx_sum", res_sum, 36'hF_FFFF_FFF0);
    check_val("mx_min", res_min, 32'hFFFF_FFFF);
    check_val("mx_max", res_max, 32'hFFFF_FFFF);
    check_val("mx_n",   res_n, 16);
    handshake();
    check_val("mx_valid_drop", res_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdc_meas_seq.md
# tdc_meas_seq

Measurement sequencer for the `tdc_delay` time-to-digital converter. It replaces direct pin control of the TDC start/stop inputs. On a `go` command it runs a burst of 1–16 start/stop measurements with a programmable start-to-stop interval. For each measurement it captures the 32-bit `time_count` after a settle window and accumulates sum, minimum and maximum. The burst result is presented on a valid/ready interface to the top-level readout mux.

## Interface
- `CNT_W`, 32: width of TDC `time_count`.
- `SETTLE`, 4: cycles with stop asserted before capture (≥1).
- `clk` in 1: system clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset; highest priority.
- `go` in 1: burst request; sampled only in IDLE.
- `abort` in 1: cancel burst; sampled in every non-IDLE state.
- `cfg_delay` in 8: start-to-stop interval in cycles, D = max(cfg_delay, 1); latched on `go` acceptance.
- `cfg_samples` in 4: burst length N = cfg_samples + 1; latched on `go` acceptance.
- `tdc_start` out 1: drives TDC start.
- `tdc_stop` out 1: drives TDC stop.
- `tdc_count` in CNT_W: TDC `time_count`.
- `busy` out 1: high in every state except IDLE.
- `res_valid` out 1: burst result available.
- `res_ready` in 1: consumer accepts result.
- `res_sum` out CNT_W+4: sum of N samples.
- `res_min` out CNT_W: smallest sample.
- `res_max` out CNT_W: largest sample.
- `res_n` out 5: samples taken (1..16).

## Operation
- States: IDLE, START, SETTLE, CAPTURE, GAP, DONE.
- IDLE: `go`=1 → latch config, clear accumulators (sum=0, min=all-ones, max=0, n=0) → START.
- START: `tdc_start`=1, `tdc_stop`=0 for D cycles → SETTLE.
- SETTLE: `tdc_start`=1, `tdc_stop`=1 for SETTLE cycles → CAPTURE.
- CAPTURE: both outputs still high, 1 cycle. Register `tdc_count` on the exit edge: sum += sample; min/max updated with unsigned compare; n += 1 → GAP.
- GAP: both outputs low for 2 cycles. Then, if n < N → START; else → DONE.
- DONE: `res_*` driven from the accumulators and held stable; `res_valid`=1. When `res_valid && res_ready` → IDLE; `res_valid` drops the next cycle.
- Result outputs keep their last values in IDLE. They are meaningful only while `res_valid`=1.
- `abort`=1 in any non-IDLE state (including DONE) → IDLE on that edge. Next cycle: `tdc_start`=`tdc_stop`=`res_valid`=`busy`=0. No result is produced.
- `go` in any state other than IDLE is ignored. It is not queued.
- Config input changes during a burst have no effect.
- Arithmetic: sum width CNT_W+4 cannot overflow (16·(2^CNT_W−1) fits).
- `rst` mid-operation behaves like `abort` and additionally zeroes all result registers.

## Timing
- Reset values: state IDLE; `tdc_start`, `tdc_stop`, `busy`, `res_valid` = 0; `res_sum`, `res_min`, `res_max`, `res_n` = 0.
- All outputs are registered; no combinational input→output paths.
- `go` accepted at edge 0 → `busy` and `tdc_start` high from cycle 1.
- Per-sample period: D + SETTLE + 3 cycles.
  - `tdc_start` high D + SETTLE + 1 cycles.
  - `tdc_stop` high SETTLE + 1 cycles.
  - Low gap: 2 cycles.
- `res_valid` rises at cycle N·(D + SETTLE + 3) + 1 after the `go` edge.
- The captured sample is the `tdc_count` value present in the CAPTURE cycle.
- Handshake completes in the cycle with `res_valid && res_ready`. The earliest subsequent `go` is accepted one cycle later.
- `abort` and `res_ready` in the same DONE cycle both lead to IDLE.
- `abort` in the cycle `go` is accepted is ignored, because the state is still IDLE.

## Test plan
- Single sample: `cfg_delay`=3, `cfg_samples`=0, SETTLE=4, `tdc_count`=0x000000FF. Required: `tdc_start` high cycles 1–8; `tdc_stop` high cycles 4–8; `res_valid` at cycle 11; sum=0xFF, min=max=0xFF, n=1.
- Burst of 4: `cfg_samples`=3, captured values 10, 40, 20, 30. Required: sum=100, min=10, max=40, n=4; exactly four start pulses, each separated by a 2-cycle low gap.
- `cfg_delay`=0: behaves exactly as `cfg_delay`=1 (`tdc_start` leads `tdc_stop` by 1 cycle).
- Backpressure: hold `res_ready`=0 for 5 cycles and pulse `go` during DONE. Required: results stable, `go` ignored, `busy`=1. Then `res_ready`=1 → IDLE, `res_valid`=0 the next cycle.
- Abort/reset: `abort` during SETTLE of sample 2 → start/stop/busy low the next cycle, no `res_valid`. Repeat with `rst`; additionally all `res_*` = 0.
- Max range: `cfg_samples`=15, all samples 0xFFFFFFFF. Required: sum=0xFFFFFFFF0, min=max=0xFFFFFFFF, n=16.
